// File: rtl/regfile_sb.sv
// regfile_sb: register file with a per-register pending-write scoreboard.
// Each register carries a small counter of in-flight writes. Issue increments
// the destination counter, and writeback decrements it. An issue is held off
// on RAW hazards and when the destination counter is already full.
//
// Optional feature: define REGFILE_BYPASS_EN to forward same-cycle writeback
// data to the read ports. With it, the last pending write completing in the
// same cycle does not stall a reader.
//
// Ports:
//   clk, rst           clock and asynchronous active-low reset
//   issue_valid/ready  issue handshake; ready does not depend on valid
//   issue_rs_addr/en   packed source addresses and per-port use flags
//   issue_rd_we/addr   destination of the issuing instruction
//   rs_data            packed combinational read data, one slot per source port
//   wb_valid/we/addr/data  writeback; always accepted
//   busy_vec           one bit per register, set when its counter is nonzero
//   err_underflow      sticky flag: a writeback found no pending write
module regfile_sb #(
  parameter int unsigned REG_ADDR_WIDTH = 5,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned NUM_RD         = 2,
  parameter int unsigned CNT_WIDTH      = 2
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               issue_valid,
  output logic                               issue_ready,
  input  logic [NUM_RD*REG_ADDR_WIDTH-1:0]   issue_rs_addr,
  input  logic [NUM_RD-1:0]                  issue_rs_en,
  input  logic                               issue_rd_we,
  input  logic [REG_ADDR_WIDTH-1:0]          issue_rd_addr,
  output logic [NUM_RD*DATA_WIDTH-1:0]       rs_data,
  input  logic                               wb_valid,
  input  logic                               wb_we,
  input  logic [REG_ADDR_WIDTH-1:0]          wb_addr,
  input  logic [DATA_WIDTH-1:0]              wb_data,
  output logic [(2**REG_ADDR_WIDTH)-1:0]     busy_vec,
  output logic                               err_underflow
);

  localparam int unsigned NUM_REGS = 2 ** REG_ADDR_WIDTH;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [CNT_WIDTH-1:0]  cnt_q  [NUM_REGS];
  logic [CNT_WIDTH-1:0]  cnt_d  [NUM_REGS];
  logic                  err_q, err_d;

  logic                  wb_fire, inc_fire, dest_full;
  logic [NUM_RD-1:0]     src_haz;
  logic [NUM_REGS-1:0]   inc_vec, dec_vec;

  // Register 0 is excluded here, so it is never written and never counted.
  assign wb_fire  = wb_valid && wb_we && (wb_addr != '0);
  assign inc_fire = issue_valid && issue_ready && issue_rd_we && (issue_rd_addr != '0);

  assign dest_full   = issue_rd_we && (issue_rd_addr != '0) && (cnt_q[issue_rd_addr] == CNT_MAX);
  assign issue_ready = !(|src_haz) && !dest_full;

  always_comb begin
    rs_data = '0;
    src_haz = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      logic [REG_ADDR_WIDTH-1:0] a;
      logic                      hit;
      a   = issue_rs_addr[i*REG_ADDR_WIDTH +: REG_ADDR_WIDTH];
      hit = wb_fire && (wb_addr == a);
`ifdef REGFILE_BYPASS_EN
      // The writeback retiring the only pending write satisfies the read now.
      src_haz[i] = issue_rs_en[i] && (a != '0) && (cnt_q[a] != '0) &&
                   !((cnt_q[a] == CNT_ONE) && hit);
      rs_data[i*DATA_WIDTH +: DATA_WIDTH] = hit ? wb_data : regs_q[a];
`else
      src_haz[i] = issue_rs_en[i] && (a != '0) && (cnt_q[a] != '0);
      rs_data[i*DATA_WIDTH +: DATA_WIDTH] = hit ? regs_q[a] : regs_q[a];
`endif
    end
  end

  assign inc_vec = inc_fire ? (NUM_REGS'(1) << issue_rd_addr) : '0;
  assign dec_vec = wb_fire  ? (NUM_REGS'(1) << wb_addr)       : '0;

  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    for (int r = 1; r < NUM_REGS; r++) begin
      if (inc_vec[r] && !dec_vec[r]) begin
        cnt_d[r] = cnt_q[r] + CNT_ONE;
      end else if (dec_vec[r] && !inc_vec[r]) begin
        // No wrap on underflow: hold at zero and flag it.
        if (cnt_q[r] == '0) err_d = 1'b1;
        else                cnt_d[r] = cnt_q[r] - CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        regs_q[r] <= '0;
        cnt_q[r]  <= '0;
      end
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
      if (wb_fire) regs_q[wb_addr] <= wb_data;
    end
  end

  always_comb begin
    busy_vec = '0;
    for (int r = 0; r < NUM_REGS; r++) busy_vec[r] = |cnt_q[r];
  end

  assign err_underflow = err_q;

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb at default parameters (32 x 32-bit, 2 read
// ports, 2-bit counters). Expectations follow REGFILE_BYPASS_EN when defined.
module tb_regfile_sb;

  logic        clk = 1'b0;
  logic        rst;
  logic        issue_valid;
  logic        issue_ready;
  logic [9:0]  issue_rs_addr;
  logic [1:0]  issue_rs_en;
  logic        issue_rd_we;
  logic [4:0]  issue_rd_addr;
  logic [63:0] rs_data;
  logic        wb_valid;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic [31:0] busy_vec;
  logic        err_underflow;

  int n_cmp = 0;
  int n_bad = 0;

  regfile_sb dut (
    .clk           (clk),
    .rst           (rst),
    .issue_valid   (issue_valid),
    .issue_ready   (issue_ready),
    .issue_rs_addr (issue_rs_addr),
    .issue_rs_en   (issue_rs_en),
    .issue_rd_we   (issue_rd_we),
    .issue_rd_addr (issue_rd_addr),
    .rs_data       (rs_data),
    .wb_valid      (wb_valid),
    .wb_we         (wb_we),
    .wb_addr       (wb_addr),
    .wb_data       (wb_data),
    .busy_vec      (busy_vec),
    .err_underflow (err_underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    issue_valid = 0; issue_rs_en = 0; issue_rd_we = 0; issue_rd_addr = 0;
    issue_rs_addr = 0; wb_valid = 0; wb_we = 0; wb_addr = 0; wb_data = 0;
  endtask

  task automatic issue_wr(input logic [4:0] rd);
    issue_valid = 1; issue_rd_we = 1; issue_rd_addr = rd; issue_rs_en = 0;
  endtask

  task automatic wb(input logic [4:0] a, input logic [31:0] d);
    wb_valid = 1; wb_we = 1; wb_addr = a; wb_data = d;
  endtask

  initial begin
    idle();
    rst = 0;
    issue_rs_addr = {5'd0, 5'd5};
    #12;
    chk("reset_busy", 64'(busy_vec), 64'd0);
    chk("reset_ready", 64'(issue_ready), 64'd1);
    chk("reset_err", 64'(err_underflow), 64'd0);
    chk("reset_rs0", 64'(rs_data[31:0]), 64'd0);
    step();
    rst = 1;
    step();

    // Issue writing x5, then a reader of x5 stalls.
    issue_wr(5'd5);
    #1 chk("issue_x5_ready", 64'(issue_ready), 64'd1);
    step();
    idle();
    issue_valid = 1; issue_rs_addr = {5'd0, 5'd5}; issue_rs_en = 2'b01;
    #1;
    chk("busy_x5", 64'(busy_vec[5]), 64'd1);
    chk("raw_x5_stall", 64'(issue_ready), 64'd0);

    // Writeback of x5 in the same cycle as the reader.
    wb(5'd5, 32'hDEADBEEF);
    #1;
`ifdef REGFILE_BYPASS_EN
    chk("bypass_ready", 64'(issue_ready), 64'd1);
    chk("bypass_data", 64'(rs_data[31:0]), 64'hDEADBEEF);
`else
    chk("nobypass_ready", 64'(issue_ready), 64'd0);
    chk("nobypass_data", 64'(rs_data[31:0]), 64'd0);
`endif
    step();
    wb_valid = 0; wb_we = 0;
    #1;
    chk("after_wb_ready", 64'(issue_ready), 64'd1);
    chk("after_wb_data", 64'(rs_data[31:0]), 64'hDEADBEEF);
    chk("after_wb_busy", 64'(busy_vec), 64'd0);
    idle();

    // Fill x7's counter to 3, then destination-full stall.
    for (int k = 0; k < 3; k++) begin
      issue_wr(5'd7);
      #1 chk("fill_x7_ready", 64'(issue_ready), 64'd1);
      step();
    end
    #1;
    chk("x7_full_stall", 64'(issue_ready), 64'd0);
    chk("x7_busy", 64'(busy_vec[7]), 64'd1);
    wb(5'd7, 32'h77);
    #1 chk("x7_full_wb_cycle", 64'(issue_ready), 64'd0);
    step();
    wb_valid = 0; wb_we = 0;
    #1 chk("x7_ready_back", 64'(issue_ready), 64'd1);
    idle();

    // Same-cycle increment and decrement of x3 leaves counter at 1.
    issue_wr(5'd3);
    step();
    wb(5'd3, 32'h33);
    #1 chk("x3_both_ready", 64'(issue_ready), 64'd1);
    step();
    idle();
    issue_rs_addr = {5'd3, 5'd0};
    #1;
    chk("x3_busy_kept", 64'(busy_vec[3]), 64'd1);
    chk("x3_data", 64'(rs_data[63:32]), 64'h33);
    chk("x3_no_err", 64'(err_underflow), 64'd0);
    wb(5'd3, 32'h34);
    step();
    idle();
    #1;
    chk("x3_drained", 64'(busy_vec[3]), 64'd0);
    chk("x3_drain_no_err", 64'(err_underflow), 64'd0);

    // Underflow on x9, write still lands.
    wb(5'd9, 32'h1234);
    step();
    idle();
    issue_rs_addr = {5'd0, 5'd9};
    #1;
    chk("x9_data", 64'(rs_data[31:0]), 64'h1234);
    chk("x9_underflow", 64'(err_underflow), 64'd1);
    chk("x9_not_busy", 64'(busy_vec[9]), 64'd0);
    // wb_we low changes nothing.
    wb_valid = 1; wb_we = 0; wb_addr = 5'd9; wb_data = 32'hAAAA;
    step();
    idle();
    issue_rs_addr = {5'd0, 5'd9};
    #1 chk("x9_we0_kept", 64'(rs_data[31:0]), 64'h1234);
    // x0 is never written.
    wb(5'd0, 32'hFFFF);
    step();
    idle();
    #1;
    chk("x0_zero", 64'(rs_data[31:0]), 64'd0);
    chk("x0_not_busy", 64'(busy_vec[0]), 64'd0);

    // Counter(x5)=2, then asynchronous reset mid-operation.
    issue_wr(5'd5);
    step();
    step();
    idle();
    issue_rs_addr = {5'd0, 5'd5}; issue_rs_en = 2'b01;
    #1;
    chk("x5_two_stall", 64'(issue_ready), 64'd0);
    #1 rst = 0;
    #1;
    chk("rst_busy", 64'(busy_vec), 64'd0);
    chk("rst_ready", 64'(issue_ready), 64'd1);
    chk("rst_x5", 64'(rs_data[31:0]), 64'd0);
    chk("rst_err", 64'(err_underflow), 64'd0);
    step();
    rst = 1;
    step();
    wb(5'd5, 32'h55);
    step();
    idle();
    #1 chk("post_rst_underflow", 64'(err_underflow), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
